// File: rtl/l2_ram_pkg.sv
// Shared types for the L2 RAM bank array.
// The FSM state encoding and the per-bank request bundle live here.
package l2_ram_pkg;

    // The request struct is sized for the default array geometry.
    localparam int unsigned L2_ADDR_W = 15;
    localparam int unsigned L2_DATA_W = 32;
    localparam int unsigned L2_BE_W   = L2_DATA_W / 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_READY
    } state_e;

    typedef struct packed {
        logic                 req;
        logic                 we;
        logic [L2_ADDR_W-1:0] addr;
        logic [L2_BE_W-1:0]   be;
        logic [L2_DATA_W-1:0] wdata;
    } bank_req_t;

    function automatic logic addr_oob(input logic [31:0] addr, input int unsigned words);
        return addr >= words;
    endfunction

endpackage

// File: rtl/l2_ram_bank_array_if.sv
// Per-bank request/response bus of the L2 RAM bank array.
// The master drives requests; the slave (the array) answers with grant and response.
interface l2_ram_bank_array_if #(
    parameter int NB_BANKS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 15
);
    logic [NB_BANKS-1:0]                   req_i;
    logic [NB_BANKS-1:0]                   we_i;
    logic [NB_BANKS-1:0][ADDR_WIDTH-1:0]   addr_i;
    logic [NB_BANKS-1:0][DATA_WIDTH/8-1:0] be_i;
    logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   wdata_i;
    logic [NB_BANKS-1:0]                   gnt_o;
    logic [NB_BANKS-1:0]                   rvalid_o;
    logic [NB_BANKS-1:0]                   err_o;
    logic [NB_BANKS-1:0][DATA_WIDTH-1:0]   rdata_o;

    modport master (
        output req_i, we_i, addr_i, be_i, wdata_i,
        input  gnt_o, rvalid_o, err_o, rdata_o
    );

    modport slave (
        input  req_i, we_i, addr_i, be_i, wdata_i,
        output gnt_o, rvalid_o, err_o, rdata_o
    );
endinterface

// File: rtl/l2_ram_hybrid_bank.sv
// One L2 bank: low words in SRAM, the top SCM_WORDS words in SCM.
// Single-port, byte-enabled writes, registered read data one cycle after a read.
module l2_ram_hybrid_bank #(
    parameter int DATA_WIDTH = 32,
    parameter int BANK_WORDS = 29184,
    parameter int SCM_WORDS  = 512,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                    clk_i,
    input  logic                    req_i,
    input  logic                    we_i,
    input  logic [ADDR_WIDTH-1:0]   addr_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   wdata_i,
    output logic [DATA_WIDTH-1:0]   rdata_o
);
    localparam int BE_W       = DATA_WIDTH / 8;
    localparam int SRAM_WORDS = BANK_WORDS - SCM_WORDS;
    localparam int SRAM_AW    = (SRAM_WORDS > 1) ? $clog2(SRAM_WORDS) : 1;
    localparam int SCM_AW     = (SCM_WORDS > 1) ? $clog2(SCM_WORDS) : 1;

    logic                  in_scm;
    logic [SRAM_AW-1:0]    sram_idx;
    logic [SCM_AW-1:0]     scm_idx;
    logic [DATA_WIDTH-1:0] scm_rdata;

    assign in_scm   = 32'(addr_i) >= 32'(SRAM_WORDS);
    assign sram_idx = SRAM_AW'(addr_i);
    assign scm_idx  = SCM_AW'(addr_i - ADDR_WIDTH'(SRAM_WORDS));

`ifdef SYNTHESIS
    logic [DATA_WIDTH-1:0] sram_rdata;
    logic                  sel_scm_q;

    tc_sram_sp #(.NUM_WORDS(SRAM_WORDS), .DATA_WIDTH(DATA_WIDTH)) u_sram (
        .clk_i, .req_i(req_i & ~in_scm), .we_i, .addr_i(sram_idx),
        .be_i, .wdata_i, .rdata_o(sram_rdata)
    );
    tc_scm_sp #(.NUM_WORDS(SCM_WORDS), .DATA_WIDTH(DATA_WIDTH)) u_scm (
        .clk_i, .req_i(req_i & in_scm), .we_i, .addr_i(scm_idx),
        .be_i, .wdata_i, .rdata_o(scm_rdata)
    );

    always_ff @(posedge clk_i) begin
        if (req_i && !we_i) sel_scm_q <= in_scm;
    end
    assign rdata_o = sel_scm_q ? scm_rdata : sram_rdata;
`else
    logic [DATA_WIDTH-1:0] sram_mem [SRAM_WORDS];
    logic [DATA_WIDTH-1:0] rdata_q;

    // NOTE: memory arrays have no reset; only the CLEAR sweep zeroes them.
    always_ff @(posedge clk_i) begin
        if (req_i && we_i && !in_scm) begin
            for (int i = 0; i < BE_W; i++) begin
                if (be_i[i]) sram_mem[sram_idx][8*i +: 8] <= wdata_i[8*i +: 8];
            end
        end
    end

    if (SCM_WORDS > 0) begin : g_scm
        logic [DATA_WIDTH-1:0] scm_mem [SCM_WORDS];

        always_ff @(posedge clk_i) begin
            if (req_i && we_i && in_scm) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be_i[i]) scm_mem[scm_idx][8*i +: 8] <= wdata_i[8*i +: 8];
                end
            end
        end
        assign scm_rdata = scm_mem[scm_idx];
    end else begin : g_no_scm
        assign scm_rdata = '0;
    end

    always_ff @(posedge clk_i) begin
        if (req_i && !we_i) rdata_q <= in_scm ? scm_rdata : sram_mem[sram_idx];
    end
    assign rdata_o = rdata_q;
`endif

endmodule

// File: rtl/l2_ram_bank_array.sv
// NB_BANKS independent L2 banks behind a zero-fill FSM (IDLE/CLEAR/READY).
// CLEAR sweeps every bank in parallel; external traffic is granted only in READY.
module l2_ram_bank_array
    import l2_ram_pkg::*;
#(
    parameter int NB_BANKS   = 4,
    parameter int DATA_WIDTH = 32,
    parameter int BANK_WORDS = 29184,
    parameter int SCM_WORDS  = 512,
    parameter int ADDR_WIDTH = 15
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                init_ni,
    input  logic                test_mode_i,
    output logic                init_done_o,
    l2_ram_bank_array_if.slave  bus
);
    localparam int BE_W = DATA_WIDTH / 8;

    state_e                              state_q, state_d;
    logic [ADDR_WIDTH-1:0]               cnt_q, cnt_d;
    logic                                init_ni_q;
    logic                                init_done_q;
    logic [NB_BANKS-1:0]                 gnt, oob;
    logic [NB_BANKS-1:0]                 rvalid_q, err_q, rd_pend_q, rd_oob_q;
    logic [NB_BANKS-1:0][DATA_WIDTH-1:0] bank_rdata, rdata_d, rdata_q;
    bank_req_t                           bank_req [NB_BANKS];

    // NOTE: every signal written here gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE:  state_d = (test_mode_i || init_ni) ? ST_READY : ST_CLEAR;
            ST_CLEAR: begin
                if (cnt_q == ADDR_WIDTH'(BANK_WORDS - 1)) begin
                    state_d = ST_READY;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + ADDR_WIDTH'(1);
                end
            end
            ST_READY: if (!test_mode_i && init_ni_q && !init_ni) state_d = ST_CLEAR;
            default:  state_d = ST_IDLE;
        endcase
    end

    assign gnt       = bus.req_i & {NB_BANKS{state_q == ST_READY}};
    assign bus.gnt_o = gnt;

    // The CLEAR sweep overrides external traffic, which cannot be granted then anyway.
    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            oob[b]      = addr_oob(32'(bus.addr_i[b]), BANK_WORDS);
            bank_req[b] = '0;
            if (state_q == ST_CLEAR) begin
                bank_req[b].req  = 1'b1;
                bank_req[b].we   = 1'b1;
                bank_req[b].addr = L2_ADDR_W'(cnt_q);
                bank_req[b].be   = '1;
            end else if (gnt[b] && !oob[b]) begin
                bank_req[b].req   = 1'b1;
                bank_req[b].we    = bus.we_i[b];
                bank_req[b].addr  = L2_ADDR_W'(bus.addr_i[b]);
                bank_req[b].be    = L2_BE_W'(bus.be_i[b]);
                bank_req[b].wdata = L2_DATA_W'(bus.wdata_i[b]);
            end
        end
    end

    for (genvar b = 0; b < NB_BANKS; b++) begin : g_bank
        l2_ram_hybrid_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .BANK_WORDS (BANK_WORDS),
            .SCM_WORDS  (SCM_WORDS),
            .ADDR_WIDTH (ADDR_WIDTH)
        ) u_bank (
            .clk_i   (clk_i),
            .req_i   (bank_req[b].req),
            .we_i    (bank_req[b].we),
            .addr_i  (ADDR_WIDTH'(bank_req[b].addr)),
            .be_i    (BE_W'(bank_req[b].be)),
            .wdata_i (DATA_WIDTH'(bank_req[b].wdata)),
            .rdata_o (bank_rdata[b])
        );
    end

    // Read data is live for the response cycle of a read, then held until the next read.
    always_comb begin
        for (int b = 0; b < NB_BANKS; b++) begin
            rdata_d[b] = rdata_q[b];
            if (rd_pend_q[b]) rdata_d[b] = rd_oob_q[b] ? '0 : bank_rdata[b];
        end
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            init_ni_q   <= 1'b1;
            init_done_q <= 1'b0;
            rvalid_q    <= '0;
            err_q       <= '0;
            rd_pend_q   <= '0;
            rd_oob_q    <= '0;
            rdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            init_ni_q   <= init_ni;
            init_done_q <= (state_d == ST_READY);
            rvalid_q    <= gnt;
            err_q       <= gnt & oob;
            rd_pend_q   <= gnt & ~bus.we_i;
            rd_oob_q    <= gnt & ~bus.we_i & oob;
            rdata_q     <= rdata_d;
        end
    end

    assign init_done_o  = init_done_q;
    assign bus.rvalid_o = rvalid_q;
    assign bus.err_o    = err_q;
    assign bus.rdata_o  = rdata_d;

endmodule

// File: tb/tb_l2_ram_bank_array.sv
// Directed bench for l2_ram_bank_array with a 64-word bank (48 SRAM + 16 SCM).
module tb_l2_ram_bank_array;
    localparam int NB = 4;
    localparam int DW = 32;
    localparam int BW = 64;
    localparam int SW = 16;
    localparam int AW = 15;

    logic clk = 1'b0;
    logic rst_n, init_n, test_mode, init_done;
    int   n_pass = 0, n_fail = 0, n_total = 0;
    int   cycles;
    logic seen_gnt;

    always #5 clk = ~clk;

    l2_ram_bank_array_if #(.NB_BANKS(NB), .DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    l2_ram_bank_array #(
        .NB_BANKS(NB), .DATA_WIDTH(DW), .BANK_WORDS(BW), .SCM_WORDS(SW), .ADDR_WIDTH(AW)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .init_ni     (init_n),
        .test_mode_i (test_mode),
        .init_done_o (init_done),
        .bus         (bus)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_bus();
        bus.req_i   = '0;
        bus.we_i    = '0;
        bus.addr_i  = '0;
        bus.be_i    = '0;
        bus.wdata_i = '0;
    endtask

    task automatic wr(input int b, input int a, input logic [31:0] d, input logic [3:0] be,
                      input logic exp_err, input string tag);
        bus.req_i[b]   = 1'b1;
        bus.we_i[b]    = 1'b1;
        bus.addr_i[b]  = AW'(a);
        bus.be_i[b]    = be;
        bus.wdata_i[b] = d;
        #1 check({tag, "_gnt"}, 128'(bus.gnt_o[b]), 128'(1'b1));
        tick();
        idle_bus();
        check({tag, "_rvalid"}, 128'(bus.rvalid_o[b]), 128'(1'b1));
        check({tag, "_err"}, 128'(bus.err_o[b]), 128'(exp_err));
    endtask

    task automatic rd(input int b, input int a, input logic [31:0] exp_d,
                      input logic exp_err, input string tag);
        bus.req_i[b]  = 1'b1;
        bus.we_i[b]   = 1'b0;
        bus.addr_i[b] = AW'(a);
        #1 check({tag, "_gnt"}, 128'(bus.gnt_o[b]), 128'(1'b1));
        tick();
        idle_bus();
        check({tag, "_rvalid"}, 128'(bus.rvalid_o[b]), 128'(1'b1));
        check({tag, "_err"}, 128'(bus.err_o[b]), 128'(exp_err));
        check({tag, "_rdata"}, 128'(bus.rdata_o[b]), 128'(exp_d));
    endtask

    initial begin
        rst_n = 1'b0; init_n = 1'b0; test_mode = 1'b0;
        idle_bus();
        #12;
        check("rst_init_done", 128'(init_done), '0);
        check("rst_rvalid", 128'(bus.rvalid_o), '0);
        check("rst_err", 128'(bus.err_o), '0);
        check("rst_rdata", 128'(bus.rdata_o), '0);

        // Release with init_ni low: one IDLE cycle, then 64 CLEAR cycles.
        tick();
        rst_n  = 1'b1;
        cycles = 0;
        while (init_done !== 1'b1 && cycles < 200) begin
            tick();
            cycles++;
            if (cycles == 10) begin
                bus.req_i = '1;
                #1 check("clear_no_gnt", 128'(bus.gnt_o), '0);
                bus.req_i = '0;
            end
        end
        check("clear_len", 128'(cycles), 128'(65));
        rd(1, 0,  32'h0, 1'b0, "init_rd0");
        rd(1, 47, 32'h0, 1'b0, "init_rd47");
        rd(1, 48, 32'h0, 1'b0, "init_rd48");
        rd(1, 63, 32'h0, 1'b0, "init_rd63");

        // Byte-enabled writes into the SCM region of bank 2.
        wr(2, 50, 32'hDEADBEEF, 4'b0101, 1'b0, "be_wr1");
        check("wr_keeps_rdata", 128'(bus.rdata_o[2]), '0);
        rd(2, 50, 32'h00AD00EF, 1'b0, "be_rd1");
        tick();
        check("rvalid_one_cycle", 128'(bus.rvalid_o[2]), '0);
        wr(2, 50, 32'h12345678, 4'b1010, 1'b0, "be_wr2");
        rd(2, 50, 32'h12AD56EF, 1'b0, "be_rd2");
        wr(0, 47, 32'h0BADF00D, 4'b1111, 1'b0, "sram_top_wr");
        rd(0, 47, 32'h0BADF00D, 1'b0, "sram_top_rd");

        // Out-of-range accesses on bank 3.
        wr(3, 63, 32'hCAFEF00D, 4'b1111, 1'b0, "scm_top_wr");
        rd(3, 63, 32'hCAFEF00D, 1'b0, "scm_top_rd");
        wr(3, 64, 32'h55555555, 4'b1111, 1'b1, "oob_wr");
        rd(3, 64, 32'h0, 1'b1, "oob_rd");
        rd(3, 48, 32'h0, 1'b0, "oob_nochg48");
        rd(3, 0,  32'h0, 1'b0, "oob_nochg0");
        rd(3, 63, 32'hCAFEF00D, 1'b0, "oob_nochg63");

        // All banks at once: write cycle directly followed by a read cycle.
        for (int b = 0; b < NB; b++) begin
            bus.req_i[b]   = 1'b1;
            bus.we_i[b]    = 1'b1;
            bus.addr_i[b]  = AW'(5);
            bus.be_i[b]    = 4'hF;
            bus.wdata_i[b] = 32'h1000 + 32'(b);
        end
        #1 check("par_wr_gnt", 128'(bus.gnt_o), 128'(4'hF));
        tick();
        check("par_wr_rvalid", 128'(bus.rvalid_o), 128'(4'hF));
        check("par_wr_err", 128'(bus.err_o), '0);
        bus.we_i = '0;
        #1 check("par_rd_gnt", 128'(bus.gnt_o), 128'(4'hF));
        tick();
        idle_bus();
        check("par_rd_rvalid", 128'(bus.rvalid_o), 128'(4'hF));
        check("par_rd_rdata", 128'(bus.rdata_o), 128'h00001003_00001002_00001001_00001000);
        wr(0, 6, 32'h00000066, 4'hF, 1'b0, "hold_wr");
        check("rdata_hold", 128'(bus.rdata_o[0]), 128'(32'h1000));

        // init_ni falling edge together with a read: the read completes, then CLEAR.
        init_n = 1'b1;
        tick();
        init_n        = 1'b0;
        bus.req_i[1]  = 1'b1;
        bus.addr_i[1] = AW'(5);
        #1 check("edge_rd_gnt", 128'(bus.gnt_o[1]), 128'(1'b1));
        tick();
        idle_bus();
        check("edge_rd_rvalid", 128'(bus.rvalid_o[1]), 128'(1'b1));
        check("edge_rd_rdata", 128'(bus.rdata_o[1]), 128'(32'h1001));
        check("edge_init_done", 128'(init_done), '0);
        cycles   = 0;
        seen_gnt = 1'b0;
        while (init_done !== 1'b1 && cycles < 200) begin
            bus.req_i = '1;
            #1 seen_gnt = seen_gnt | (|bus.gnt_o);
            bus.req_i = '0;
            tick();
            cycles++;
        end
        check("reclear_len", 128'(cycles), 128'(64));
        check("reclear_no_gnt", 128'(seen_gnt), '0);
        rd(0, 5,  32'h0, 1'b0, "reclear_b0");
        rd(1, 5,  32'h0, 1'b0, "reclear_b1");
        rd(2, 50, 32'h0, 1'b0, "reclear_b2");
        rd(3, 63, 32'h0, 1'b0, "reclear_b3");
        rd(0, 47, 32'h0, 1'b0, "reclear_b0_47");
        tick(); tick(); tick();
        check("held_low_no_retrig", 128'(init_done), 128'(1'b1));

        // Reset in the middle of a CLEAR, then restart in test mode.
        wr(0, 30, 32'h77777777, 4'hF, 1'b0, "pre_abort_wr");
        rd(0, 30, 32'h77777777, 1'b0, "pre_abort_rd");
        init_n = 1'b1;
        tick();
        init_n = 1'b0;
        tick();
        for (int i = 0; i < 20; i++) tick();
        rst_n = 1'b0;
        #1;
        check("abort_init_done", 128'(init_done), '0);
        check("abort_rvalid", 128'(bus.rvalid_o), '0);
        check("abort_err", 128'(bus.err_o), '0);
        check("abort_rdata", 128'(bus.rdata_o), '0);
        init_n    = 1'b1;
        test_mode = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        check("tm_ready_1cyc", 128'(init_done), 128'(1'b1));
        rd(0, 30, 32'h77777777, 1'b0, "tm_no_clear");
        init_n = 1'b0;
        tick(); tick();
        check("tm_edge_ignored", 128'(init_done), 128'(1'b1));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
